// File: rtl/riscv_hwloop_regfile.sv
// Hardware-loop register file: per-set start/end/counter registers with a CSR read-back port.
// Latency: writes/decrements/flush visible one cycle later; read-back data valid one cycle after request.
// Backpressure: none; one read request accepted every cycle, including while a response is being driven.
module riscv_hwloop_regfile #(
    parameter int N_REGS     = 2,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_W-1:0]              hwlp_start_data_i,
    input  logic [ADDR_W-1:0]              hwlp_end_data_i,
    input  logic [CNT_W-1:0]               hwlp_cnt_data_i,
    input  logic [2:0]                     hwlp_we_i,
    input  logic [N_REG_BITS-1:0]          hwlp_regid_i,
    input  logic                           valid_i,
    input  logic [N_REGS-1:0]              hwlp_dec_cnt_i,
    input  logic                           flush_i,
    input  logic                           rd_req_i,
    input  logic [N_REG_BITS-1:0]          rd_regid_i,
    input  logic [1:0]                     rd_sel_i,
    output logic                           rd_valid_o,
    output logic [31:0]                    rd_data_o,
    output logic [N_REGS-1:0][ADDR_W-1:0]  hwlp_start_addr_o,
    output logic [N_REGS-1:0][ADDR_W-1:0]  hwlp_end_addr_o,
    output logic [N_REGS-1:0][CNT_W-1:0]   hwlp_counter_o,
    output logic [N_REGS-1:0]              hwlp_active_o,
    output logic                           dec_err_o
);

    typedef enum logic {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

    logic [N_REGS-1:0][ADDR_W-1:0] start_q;
    logic [N_REGS-1:0][ADDR_W-1:0] end_q;
    logic [N_REGS-1:0][CNT_W-1:0]  cnt_q;
    logic [N_REGS-1:0][CNT_W-1:0]  cnt_d;
    logic [N_REGS-1:0]             active_q;
    logic                          dec_err_q;
    logic                          err_d;
    logic [N_REGS-1:0]             wr_sel;
    logic [N_REGS-1:0]             dec_req;
    logic [N_REGS-1:0]             dec_grant;
    rd_state_t                     rd_state_q;
    rd_state_t                     rd_state_d;
    logic [31:0]                   rd_data_q;
    logic [31:0]                   rd_mux;
    logic [ADDR_W+31:0]            ext_start;
    logic [ADDR_W+31:0]            ext_end;
    logic [CNT_W+31:0]             ext_cnt;

    // Write target decode: an out-of-range regid matches no set, so the write is dropped.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < N_REGS; k++) begin
            wr_sel[k] = (hwlp_regid_i == N_REG_BITS'(k));
        end
    end

    // Counter next-state: flush > counter write > granted decrement (lowest index wins, saturating).
    always_comb begin
        dec_req   = valid_i ? hwlp_dec_cnt_i : '0;
        dec_grant = dec_req & (~dec_req + N_REGS'(1));
        err_d     = dec_err_q;
        cnt_d     = cnt_q;
        if ((dec_req & ~dec_grant) != '0) begin
            err_d = 1'b1;
        end
        for (int k = 0; k < N_REGS; k++) begin
            if (hwlp_we_i[2] && wr_sel[k]) begin
                cnt_d[k] = hwlp_cnt_data_i;
            end else if (dec_grant[k]) begin
                if (cnt_q[k] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end
        end
        if (flush_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    // Counter, active flag and sticky error registers; active tracks the counter it mirrors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            active_q  <= '0;
            dec_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dec_err_q <= err_d;
            for (int k = 0; k < N_REGS; k++) begin
                active_q[k] <= |cnt_d[k];
            end
        end
    end

    // Start/end address registers; loop addresses are halfword aligned so bit 0 is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            end_q   <= '0;
        end else begin
            for (int k = 0; k < N_REGS; k++) begin
                if (hwlp_we_i[0] && wr_sel[k]) start_q[k] <= hwlp_start_data_i & ~ADDR_W'(1);
                if (hwlp_we_i[1] && wr_sel[k]) end_q[k]   <= hwlp_end_data_i & ~ADDR_W'(1);
            end
        end
    end

    // Read-back mux on current register contents; unknown set returns zero.
    always_comb begin
        rd_mux    = '0;
        ext_start = '0;
        ext_end   = '0;
        ext_cnt   = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (rd_regid_i == N_REG_BITS'(k)) begin
                ext_start = {32'b0, start_q[k]};
                ext_end   = {32'b0, end_q[k]};
                ext_cnt   = {32'b0, cnt_q[k]};
                case (rd_sel_i)
                    2'd0:    rd_mux = ext_start[31:0];
                    2'd1:    rd_mux = ext_end[31:0];
                    2'd2:    rd_mux = ext_cnt[31:0];
                    default: rd_mux = {29'b0, dec_err_q, active_q[k], 1'b0};
                endcase
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state_q <= RD_IDLE;
        else        rd_state_q <= rd_state_d;
    end

    // Read FSM next state: a request in either state produces a response next cycle.
    always_comb begin
        rd_state_d = RD_IDLE;
        case (rd_state_q)
            RD_IDLE: rd_state_d = rd_req_i ? RD_RESP : RD_IDLE;
            RD_RESP: rd_state_d = rd_req_i ? RD_RESP : RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Capture read data at the request edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rd_data_q <= '0;
        else if (rd_req_i) rd_data_q <= rd_mux;
    end

    assign rd_valid_o        = (rd_state_q == RD_RESP);
    assign rd_data_o         = rd_data_q;
    assign hwlp_start_addr_o = start_q;
    assign hwlp_end_addr_o   = end_q;
    assign hwlp_counter_o    = cnt_q;
    assign hwlp_active_o     = active_q;
    assign dec_err_o         = dec_err_q;

endmodule

// File: tb/tb_riscv_hwloop_regfile.sv
module tb_riscv_hwloop_regfile;

    logic              clk;
    logic              rst_n;
    logic [31:0]       start_data;
    logic [31:0]       end_data;
    logic [31:0]       cnt_data;
    logic [2:0]        we;
    logic [0:0]        regid;
    logic              valid;
    logic [1:0]        dec;
    logic              flush;
    logic              rd_req;
    logic [0:0]        rd_regid;
    logic [1:0]        rd_sel;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic [1:0][31:0]  start_addr;
    logic [1:0][31:0]  end_addr;
    logic [1:0][31:0]  counter;
    logic [1:0]        active;
    logic              dec_err;

    int checks = 0;
    int errors = 0;

    riscv_hwloop_regfile #(.N_REGS(2), .ADDR_W(32), .CNT_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hwlp_start_data_i (start_data),
        .hwlp_end_data_i   (end_data),
        .hwlp_cnt_data_i   (cnt_data),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .valid_i           (valid),
        .hwlp_dec_cnt_i    (dec),
        .flush_i           (flush),
        .rd_req_i          (rd_req),
        .rd_regid_i        (rd_regid),
        .rd_sel_i          (rd_sel),
        .rd_valid_o        (rd_valid),
        .rd_data_o         (rd_data),
        .hwlp_start_addr_o (start_addr),
        .hwlp_end_addr_o   (end_addr),
        .hwlp_counter_o    (counter),
        .hwlp_active_o     (active),
        .dec_err_o         (dec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_data = '0; end_data = '0; cnt_data = '0; we = '0; regid = '0;
        valid = 1'b0; dec = '0; flush = 1'b0; rd_req = 1'b0; rd_regid = '0; rd_sel = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        checks++; if (counter !== 64'h0) begin errors++; $display("FAIL reset_counter got %h exp 0", counter); end
        checks++; if (start_addr !== 64'h0 || end_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h %h exp 0", start_addr, end_addr); end
        checks++; if (active !== 2'b00 || dec_err !== 1'b0) begin errors++; $display("FAIL reset_flags got active=%b err=%b exp 0", active, dec_err); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd got v=%b d=%h exp 0", rd_valid, rd_data); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dec_sequence();
        logic [31:0] exp_cnt [4];
        logic        exp_err [4];
        exp_cnt = '{32'd2, 32'd1, 32'd0, 32'd0};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b1};
        we = 3'b100; regid = 1'b1; cnt_data = 32'd3;
        tick();
        idle_inputs();
        checks++; if (counter[1] !== 32'd3 || active !== 2'b10) begin errors++; $display("FAIL dec_load got cnt=%0d act=%b exp 3 10", counter[1], active); end
        dec = 2'b10; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (counter[1] !== exp_cnt[i] || active[1] !== (exp_cnt[i] != 0) || dec_err !== exp_err[i]) begin
                errors++;
                $display("FAIL dec_step%0d got cnt=%0d act=%b err=%b exp cnt=%0d err=%b", i, counter[1], active[1], dec_err, exp_cnt[i], exp_err[i]);
            end
        end
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dec_err !== 1'b0) begin errors++; $display("FAIL flush_clears_err got %b exp 0", dec_err); end
    endtask

    task automatic test_override();
        we = 3'b100; regid = 1'b1; cnt_data = 32'd7;
        tick();
        we = 3'b100; regid = 1'b0; cnt_data = 32'd5; dec = 2'b11; valid = 1'b1;
        tick();
        idle_inputs();
        checks++; if (counter[0] !== 32'd5 || counter[1] !== 32'd7) begin errors++; $display("FAIL override_cnt got %0d %0d exp 5 7", counter[0], counter[1]); end
        checks++; if (dec_err !== 1'b1) begin errors++; $display("FAIL override_err got %b exp 1", dec_err); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_valid_gate();
        we = 3'b100; regid = 1'b0; cnt_data = 32'd9;
        tick();
        idle_inputs();
        dec = 2'b01; valid = 1'b0;
        tick();
        tick();
        dec = '0;
        checks++; if (counter[0] !== 32'd9 || dec_err !== 1'b0) begin errors++; $display("FAIL valid_gate got cnt=%0d err=%b exp 9 0", counter[0], dec_err); end
    endtask

    task automatic test_readback();
        we = 3'b001; regid = 1'b0; start_data = 32'h0000_1003;
        tick();
        idle_inputs();
        checks++; if (start_addr[0] !== 32'h0000_1002) begin errors++; $display("FAIL start_align got %h exp 00001002", start_addr[0]); end
        rd_req = 1'b1; rd_sel = 2'd0; rd_regid = 1'b0;
        tick();
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_1002) begin errors++; $display("FAIL read_start got v=%b d=%h exp 1 00001002", rd_valid, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_pulse got v=%b exp 0", rd_valid); end
    endtask

    task automatic test_back_to_back();
        we = 3'b010; regid = 1'b1; end_data = 32'h0000_2001;
        tick();
        idle_inputs();
        checks++; if (end_addr[1] !== 32'h0000_2000 || start_addr[1] !== 32'h0) begin errors++; $display("FAIL end_write got e=%h s=%h exp 00002000 0", end_addr[1], start_addr[1]); end
        rd_req = 1'b1; rd_sel = 2'd1; rd_regid = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h0000_2000) begin errors++; $display("FAIL b2b_end got v=%b d=%h exp 1 00002000", rd_valid, rd_data); end
        rd_sel = 2'd2; rd_regid = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd9) begin errors++; $display("FAIL b2b_cnt got v=%b d=%h exp 1 9", rd_valid, rd_data); end
        rd_sel = 2'd3; rd_regid = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h2) begin errors++; $display("FAIL b2b_status got v=%b d=%h exp 1 2", rd_valid, rd_data); end
        rd_req = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_pulse got v=%b exp 0", rd_valid); end
    endtask

    task automatic test_flush();
        we = 3'b100; regid = 1'b0; cnt_data = 32'd4;
        tick();
        regid = 1'b1; cnt_data = 32'd6;
        tick();
        idle_inputs();
        checks++; if (counter[0] !== 32'd4 || counter[1] !== 32'd6 || active !== 2'b11) begin errors++; $display("FAIL flush_pre got %0d %0d act=%b exp 4 6 11", counter[0], counter[1], active); end
        flush = 1'b1; we = 3'b100; regid = 1'b0; cnt_data = 32'd3; dec = 2'b10; valid = 1'b1;
        tick();
        idle_inputs();
        checks++; if (counter !== 64'h0 || active !== 2'b00) begin errors++; $display("FAIL flush_cnt got %h act=%b exp 0 00", counter, active); end
        checks++; if (start_addr[0] !== 32'h0000_1002 || end_addr[1] !== 32'h0000_2000) begin errors++; $display("FAIL flush_addr got s=%h e=%h exp 00001002 00002000", start_addr[0], end_addr[1]); end
    endtask

    task automatic test_reset_mid_read();
        we = 3'b100; regid = 1'b1; cnt_data = 32'd8;
        tick();
        idle_inputs();
        rd_req = 1'b1; rd_sel = 2'd2; rd_regid = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd8) begin errors++; $display("FAIL pre_reset_read got v=%b d=%h exp 1 8", rd_valid, rd_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || counter !== 64'h0 || active !== 2'b00) begin errors++; $display("FAIL async_reset got v=%b d=%h cnt=%h act=%b exp 0", rd_valid, rd_data, counter, active); end
        rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b0 || start_addr !== 64'h0 || end_addr !== 64'h0) begin errors++; $display("FAIL post_reset%0d got v=%b s=%h e=%h exp 0", i, rd_valid, start_addr, end_addr); end
        end
    endtask

    initial begin
        test_reset();
        test_dec_sequence();
        test_override();
        test_valid_gate();
        test_readback();
        test_back_to_back();
        test_flush();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
